// File: rtl/fft_frame_sink.sv
// Captures one FFT output frame into a read-back buffer, tracks the peak |re|+|im| bin,
// then holds the frame until released; frames arriving while held are counted as drops.
module fft_frame_sink #(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             sop_in,
    input  logic [15:0]      re_in,
    input  logic [15:0]      im_in,
    input  logic             rd_en,
    input  logic [7:0]       rd_addr,
    input  logic             rel_in,
    output logic             rd_valid,
    output logic [15:0]      rd_re,
    output logic [15:0]      rd_im,
    output logic             frame_done,
    output logic [7:0]       peak_bin,
    output logic [16:0]      peak_mag,
    output logic             err_short,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int unsigned IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [1:0] {StIdle, StCapture, StHold} state_e;

    state_e          r_state;
    logic [IW-1:0]   r_idx;
    logic [16:0]     r_run_mag;
    logic [IW-1:0]   r_run_bin;
    logic [31:0]     r_mem [FRAME_LEN];

    logic [16:0]     w_re_ext, w_im_ext, w_re_abs, w_im_abs, w_mag;
    logic            w_sop, w_wr, w_last, w_gt, w_rd_in_range;
    logic [IW-1:0]   w_wr_idx;

    // 17-bit magnitude so that |-32768| = 32768 is exact.
    assign w_re_ext = {re_in[15], re_in};
    assign w_im_ext = {im_in[15], im_in};
    assign w_re_abs = re_in[15] ? (~w_re_ext + 17'd1) : w_re_ext;
    assign w_im_abs = im_in[15] ? (~w_im_ext + 17'd1) : w_im_ext;
    assign w_mag    = w_re_abs + w_im_abs;

    assign w_sop    = valid_in && sop_in;
    assign w_wr     = ((r_state == StIdle) && w_sop) || ((r_state == StCapture) && valid_in);
    assign w_wr_idx = sop_in ? '0 : r_idx;
    assign w_last   = (r_state == StCapture) && valid_in && !sop_in
                      && (r_idx == IW'(FRAME_LEN - 1));
    assign w_gt     = w_mag > r_run_mag;
    assign w_rd_in_range = 32'(rd_addr) < FRAME_LEN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_idx      <= '0;
            r_run_mag  <= '0;
            r_run_bin  <= '0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            busy       <= 1'b0;
            peak_bin   <= '0;
            peak_mag   <= '0;
            frame_cnt  <= '0;
            drop_cnt   <= '0;
        end else begin
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_sop) begin
                        r_idx     <= IW'(1);
                        r_run_mag <= w_mag;
                        r_run_bin <= '0;
                        busy      <= 1'b1;
                        r_state   <= StCapture;
                    end
                end
                StCapture: begin
                    if (w_sop) begin
                        // Early sop: abandon the partial frame and restart at bin 0.
                        err_short <= 1'b1;
                        r_idx     <= IW'(1);
                        r_run_mag <= w_mag;
                        r_run_bin <= '0;
                    end else if (w_last) begin
                        r_idx      <= '0;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 1'b1;
                        peak_mag   <= w_gt ? w_mag : r_run_mag;
                        peak_bin   <= w_gt ? 8'(r_idx) : 8'(r_run_bin);
                        r_state    <= StHold;
                    end else if (valid_in) begin
                        r_idx <= r_idx + 1'b1;
                        if (w_gt) begin
                            r_run_mag <= w_mag;
                            r_run_bin <= r_idx;
                        end
                    end
                end
                StHold: begin
                    if (w_sop) drop_cnt <= drop_cnt + 1'b1;
                    if (rel_in) begin
                        busy    <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[w_wr_idx] <= {re_in, im_in};
    end

    // Read port samples the array before this edge's write lands, so same-address reads see old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_re    <= '0;
            rd_im    <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                if (w_rd_in_range) begin
                    {rd_re, rd_im} <= r_mem[rd_addr[IW-1:0]];
                end else begin
                    {rd_re, rd_im} <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_sink.sv
// Scoreboard bench for fft_frame_sink: stimulus pushes expected frame/err/read events,
// a negedge monitor pops and compares them whenever the DUT pulses an output.
module tb_fft_frame_sink;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, valid_in, sop_in, rd_en, rel_in;
    logic [15:0] re_in, im_in;
    logic [7:0]  rd_addr;
    logic        rd_valid, frame_done, err_short, busy;
    logic [15:0] rd_re, rd_im, frame_cnt, drop_cnt;
    logic [7:0]  peak_bin;
    logic [16:0] peak_mag;

    // Small instance used only to reach the out-of-range read path.
    logic        s_rd_en;
    logic [7:0]  s_rd_addr;
    logic        s_rd_valid, s_frame_done, s_err_short, s_busy;
    logic [15:0] s_rd_re, s_rd_im, s_frame_cnt, s_drop_cnt;
    logic [7:0]  s_peak_bin;
    logic [16:0] s_peak_mag;

    fft_frame_sink #(.FRAME_LEN(256), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sop_in(sop_in),
        .re_in(re_in), .im_in(im_in), .rd_en(rd_en), .rd_addr(rd_addr), .rel_in(rel_in),
        .rd_valid(rd_valid), .rd_re(rd_re), .rd_im(rd_im), .frame_done(frame_done),
        .peak_bin(peak_bin), .peak_mag(peak_mag), .err_short(err_short), .busy(busy),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    fft_frame_sink #(.FRAME_LEN(16), .CNT_W(16)) u_small (
        .clk(clk), .rst_n(rst_n), .valid_in(1'b0), .sop_in(1'b0),
        .re_in(16'd0), .im_in(16'd0), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rel_in(1'b0),
        .rd_valid(s_rd_valid), .rd_re(s_rd_re), .rd_im(s_rd_im), .frame_done(s_frame_done),
        .peak_bin(s_peak_bin), .peak_mag(s_peak_mag), .err_short(s_err_short), .busy(s_busy),
        .frame_cnt(s_frame_cnt), .drop_cnt(s_drop_cnt)
    );

    typedef struct packed {logic [7:0] bin; logic [16:0] mag; logic [15:0] cnt;} frame_exp_t;
    typedef struct packed {logic [15:0] re; logic [15:0] im;} rd_exp_t;

    frame_exp_t q_frame[$];
    rd_exp_t    q_rd[$];
    int         n_err_exp = 0;
    int         n_checks  = 0;
    int         n_errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: pulse with nothing expected", name);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done) begin
                if (q_frame.size() == 0) unexpected("frame_done");
                else begin
                    frame_exp_t e;
                    e = q_frame.pop_front();
                    chk("peak_bin", 32'(peak_bin), 32'(e.bin));
                    chk("peak_mag", 32'(peak_mag), 32'(e.mag));
                    chk("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
                end
            end
            if (err_short) begin
                if (n_err_exp == 0) unexpected("err_short");
                else n_err_exp--;
            end
            if (rd_valid) begin
                if (q_rd.size() == 0) unexpected("rd_valid");
                else begin
                    rd_exp_t r;
                    r = q_rd.pop_front();
                    chk("rd_re", 32'(rd_re), 32'(r.re));
                    chk("rd_im", 32'(rd_im), 32'(r.im));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] re, input logic [15:0] im, input logic sop);
        valid_in = 1'b1;
        sop_in   = sop;
        re_in    = re;
        im_in    = im;
        tick();
        valid_in = 1'b0;
        sop_in   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] ere, input logic [15:0] eim);
        q_rd.push_back('{re: ere, im: eim});
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic release_buf();
        rel_in = 1'b1;
        tick();
        rel_in = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_flags"}, 32'({frame_done, err_short, rd_valid, busy}), 32'd0);
        chk({tag, "_peak"}, 32'({peak_bin, peak_mag}), 32'd0);
        chk({tag, "_rdata"}, {rd_re, rd_im}, 32'd0);
        chk({tag, "_cnts"}, {frame_cnt, drop_cnt}, 32'd0);
    endtask

    // Ramp re=k, im=+/-k for k=1..256; optional 3-cycle gaps every 8 samples and a
    // same-address read at sample rd_at that must return the previous content (k,k).
    task automatic send_ramp(input bit neg_im, input bit gaps, input int rd_at);
        for (int k = 1; k <= 256; k++) begin
            if (gaps && k > 1 && ((k - 1) % 8) == 0) repeat (3) tick();
            if (k == rd_at) begin
                rd_en   = 1'b1;
                rd_addr = 8'(k - 1);
                q_rd.push_back('{re: 16'(k), im: 16'(k)});
            end
            send(16'(k), neg_im ? 16'(-k) : 16'(k), k == 1);
            rd_en = 1'b0;
        end
        chk("frame_done_timing", 32'(frame_done), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; sop_in = 1'b0; re_in = '0; im_in = '0;
        rd_en = 1'b0; rd_addr = '0; rel_in = 1'b0; s_rd_en = 1'b0; s_rd_addr = '0;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // Non-sop samples and rel_in in IDLE are ignored.
        repeat (3) send(16'd7, 16'd7, 1'b0);
        release_buf();
        chk("idle_ignore_busy", 32'(busy), 32'd0);

        // Continuous ramp frame.
        q_frame.push_back('{bin: 8'd255, mag: 17'd512, cnt: 16'd1});
        send_ramp(1'b0, 1'b0, 0);
        chk("hold_busy", 32'(busy), 32'd1);
        rd(8'd0, 16'd1, 16'd1);
        rd(8'd255, 16'd256, 16'd256);
        rd(8'd100, 16'd101, 16'd101);

        // Second frame while held is dropped; buffer keeps frame 1.
        send(16'd50, 16'd50, 1'b1);
        repeat (19) send(16'd50, 16'd50, 1'b0);
        chk("drop_cnt_1", 32'(drop_cnt), 32'd1);
        rd(8'd5, 16'd6, 16'd6);
        chk("peak_hold", 32'(peak_bin), 32'd255);
        // sop coinciding with release is dropped and counted.
        rel_in = 1'b1;
        send(16'd9, 16'd9, 1'b1);
        rel_in = 1'b0;
        chk("drop_cnt_2", 32'(drop_cnt), 32'd2);
        chk("released_busy", 32'(busy), 32'd0);
        chk("frame_cnt_after_drop", 32'(frame_cnt), 32'd1);

        // All (5,-5): ties keep bin 0; rel_in mid-capture has no effect.
        q_frame.push_back('{bin: 8'd0, mag: 17'd10, cnt: 16'd2});
        for (int k = 0; k < 256; k++) begin
            rel_in = (k == 50);
            send(16'd5, 16'hFFFB, k == 0);
        end
        rel_in = 1'b0;
        rd(8'd3, 16'd5, 16'hFFFB);
        release_buf();

        // Single full-scale negative sample at bin 77.
        q_frame.push_back('{bin: 8'd77, mag: 17'd65536, cnt: 16'd3});
        for (int k = 0; k < 256; k++) begin
            if (k == 77) send(16'h8000, 16'h8000, 1'b0);
            else send(16'd0, 16'd0, k == 0);
        end
        rd(8'd77, 16'h8000, 16'h8000);
        release_buf();

        // Early sop at sample 100 restarts the frame.
        n_err_exp++;
        q_frame.push_back('{bin: 8'd255, mag: 17'd512, cnt: 16'd4});
        send(16'd1, 16'd1, 1'b1);
        repeat (98) send(16'd2, 16'd2, 1'b0);
        send_ramp(1'b0, 1'b0, 0);
        release_buf();

        // Asynchronous reset mid-capture.
        for (int k = 1; k <= 119; k++) send(16'(k), 16'(k), k == 1);
        #2 rst_n = 1'b0;
        #2 check_zero("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        repeat (10) send(16'd3, 16'd3, 1'b0);
        chk("post_reset_ignore", 32'(busy), 32'd0);

        // Gapped ramp with im=-k; read-before-write at bin 8.
        q_frame.push_back('{bin: 8'd255, mag: 17'd512, cnt: 16'd1});
        send_ramp(1'b1, 1'b1, 9);
        rd(8'd0, 16'd1, 16'hFFFF);
        rd(8'd7, 16'd8, 16'hFFF8);
        rd(8'd8, 16'd9, 16'hFFF7);
        rd(8'd255, 16'd256, 16'hFF00);

        // Out-of-range read on the 16-entry instance returns zero with valid.
        s_rd_en = 1'b1;
        s_rd_addr = 8'd20;
        tick();
        s_rd_en = 1'b0;
        chk("oor_valid", 32'(s_rd_valid), 32'd1);
        chk("oor_data", {s_rd_re, s_rd_im}, 32'd0);

        repeat (4) tick();
        chk("frames_pending", 32'(q_frame.size()), 32'd0);
        chk("reads_pending", 32'(q_rd.size()), 32'd0);
        chk("err_pending", 32'(n_err_exp), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
